// File: rtl/i2c_line_conditioner.sv
// Paces software-requested SCL/SDA levels onto open-drain pads, waits out clock stretching,
// filters pad readback and flags START/STOP, stretch timeout and arbitration loss.
// Optional clock-stretch support: define I2C_LINE_COND_STRETCH_EN.
module i2c_line_conditioner #(
  parameter int unsigned MIN_LOW     = 250,
  parameter int unsigned MIN_HIGH    = 250,
  parameter int unsigned SDA_HOLD    = 15,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned STRETCH_MAX = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_req,
  input  logic sda_req,
  input  logic clear_flags,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_oe,
  output logic sda_oe,
  output logic scl_sync,
  output logic sda_sync,
  output logic busy,
  output logic bus_busy,
  output logic stretch_timeout,
  output logic arb_lost
);

  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] MinLowM1  = CNT_W'(MIN_LOW - 1);
  localparam logic [CNT_W-1:0] MinHighM1 = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] SdaHold   = CNT_W'(SDA_HOLD);
  localparam logic [CNT_W-1:0] FiltM1    = CNT_W'(FILT_LEN - 1);

  if (MIN_LOW == 0 || MIN_HIGH == 0 || FILT_LEN == 0 || STRETCH_MAX >= (2 ** CNT_W)) begin
    : g_bad_params
    $error("i2c_line_conditioner: timing parameters out of range");
  end

  typedef enum logic [1:0] {StHigh, StLow, StRelease} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CNT_W'(1);
  endfunction

  // Returns {filtered level, run counter}; a change is accepted after FILT_LEN differing cycles.
  function automatic logic [CNT_W:0] filt_next(input logic s, input logic f,
                                               input logic [CNT_W-1:0] c);
    if (s == f) return {f, {CNT_W{1'b0}}};
    if (c >= FiltM1) return {s, {CNT_W{1'b0}}};
    return {f, sat_inc(c)};
  endfunction

  logic             scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
  logic             sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
  logic             scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
  logic [CNT_W-1:0] scl_fcnt_q, scl_fcnt_d, sda_fcnt_q, sda_fcnt_d;
  logic             sda_prev_q, sda_prev_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic             bus_busy_q, bus_busy_d;
  logic             arb_q, arb_d;
  logic             start_det, stop_det, arb_set;
`ifdef I2C_LINE_COND_STRETCH_EN
  logic [CNT_W-1:0] stretch_cnt_q, stretch_cnt_d;
  logic             st_q, st_d, st_set;
`endif

  always_comb begin
    scl_s1_d   = scl_in;
    scl_s2_d   = scl_s1_q;
    sda_s1_d   = sda_in;
    sda_s2_d   = sda_s1_q;
    {scl_filt_d, scl_fcnt_d} = filt_next(scl_s2_q, scl_filt_q, scl_fcnt_q);
    {sda_filt_d, sda_fcnt_d} = filt_next(sda_s2_q, sda_filt_q, sda_fcnt_q);
    sda_prev_d = sda_filt_q;

    state_d  = state_q;
    sda_oe_d = sda_oe_q;
`ifdef I2C_LINE_COND_STRETCH_EN
    stretch_cnt_d = stretch_cnt_q;
    st_set        = 1'b0;
`endif
    case (state_q)
      StHigh: begin
        if (hold_cnt_q >= MinHighM1) begin
          if (!scl_req) state_d = StLow;
          else          sda_oe_d = ~sda_req;
        end
      end
      StLow: begin
`ifdef I2C_LINE_COND_STRETCH_EN
        stretch_cnt_d = '0;
`endif
        if (hold_cnt_q >= SdaHold) sda_oe_d = ~sda_req;
        if (scl_req && hold_cnt_q >= MinLowM1) state_d = StRelease;
      end
      StRelease: begin
`ifdef I2C_LINE_COND_STRETCH_EN
        if (scl_filt_q) begin
          state_d = StHigh;
        end else if (!scl_req) begin
          state_d = StLow;
        end else begin
          if (stretch_cnt_q >= CNT_W'(STRETCH_MAX)) st_set = 1'b1;
          stretch_cnt_d = sat_inc(stretch_cnt_q);
        end
`else
        state_d = StHigh;
`endif
      end
      default: state_d = StHigh;
    endcase

    hold_cnt_d = (state_d != state_q) ? '0 : sat_inc(hold_cnt_q);
    scl_oe_d   = (state_d == StLow);

    start_det  = sda_prev_q & ~sda_filt_q & scl_filt_q;
    stop_det   = ~sda_prev_q & sda_filt_q & scl_filt_q;
    bus_busy_d = start_det ? 1'b1 : (stop_det ? 1'b0 : bus_busy_q);

    // We released SDA but read it low while SCL is ours to hold high.
    arb_set = (state_q == StHigh) & ~sda_oe_q & ~sda_filt_q & ~start_det;
    arb_d   = arb_set | (arb_q & ~clear_flags);
`ifdef I2C_LINE_COND_STRETCH_EN
    st_d    = st_set | (st_q & ~clear_flags);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1_q      <= 1'b1;
      scl_s2_q      <= 1'b1;
      sda_s1_q      <= 1'b1;
      sda_s2_q      <= 1'b1;
      scl_filt_q    <= 1'b1;
      sda_filt_q    <= 1'b1;
      scl_fcnt_q    <= '0;
      sda_fcnt_q    <= '0;
      sda_prev_q    <= 1'b1;
      state_q       <= StHigh;
      hold_cnt_q    <= '0;
      scl_oe_q      <= 1'b0;
      sda_oe_q      <= 1'b0;
      bus_busy_q    <= 1'b0;
      arb_q         <= 1'b0;
`ifdef I2C_LINE_COND_STRETCH_EN
      stretch_cnt_q <= '0;
      st_q          <= 1'b0;
`endif
    end else begin
      scl_s1_q      <= scl_s1_d;
      scl_s2_q      <= scl_s2_d;
      sda_s1_q      <= sda_s1_d;
      sda_s2_q      <= sda_s2_d;
      scl_filt_q    <= scl_filt_d;
      sda_filt_q    <= sda_filt_d;
      scl_fcnt_q    <= scl_fcnt_d;
      sda_fcnt_q    <= sda_fcnt_d;
      sda_prev_q    <= sda_prev_d;
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      scl_oe_q      <= scl_oe_d;
      sda_oe_q      <= sda_oe_d;
      bus_busy_q    <= bus_busy_d;
      arb_q         <= arb_d;
`ifdef I2C_LINE_COND_STRETCH_EN
      stretch_cnt_q <= stretch_cnt_d;
      st_q          <= st_d;
`endif
    end
  end

  assign scl_oe   = scl_oe_q;
  assign sda_oe   = sda_oe_q;
  assign scl_sync = scl_filt_q;
  assign sda_sync = sda_filt_q;
  // oe=1 drives low, so applied level differs from the request exactly when oe equals req.
  assign busy     = (scl_oe_q == scl_req) | (sda_oe_q == sda_req);
  assign bus_busy = bus_busy_q;
  assign arb_lost = arb_q;
`ifdef I2C_LINE_COND_STRETCH_EN
  assign stretch_timeout = st_q;
`else
  assign stretch_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Scoreboard bench for i2c_line_conditioner: stimulus queues cycle-stamped expectations,
// a negedge monitor compares them; a second monitor checks SCL low/high widths.
module tb_i2c_line_conditioner;

  localparam int BSclOe = 7, BSdaOe = 6, BSclSync = 5, BSdaSync = 4;
  localparam int BBusy = 3, BBusBusy = 2, BSt = 1, BArb = 0;

  logic clk = 1'b0, reset_n = 1'b0;
  logic scl_req = 1'b1, sda_req = 1'b1, clear_flags = 1'b0;
  logic slave_low = 1'b0, force_sda = 1'b0;
  logic scl_in, sda_in;
  logic scl_oe, sda_oe, scl_sync, sda_sync, busy, bus_busy, stretch_timeout, arb_lost;
  logic [7:0] obs;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    int         at;
    logic [7:0] mask;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  // Open-drain pads with pull-ups.
  assign scl_in = ~scl_oe & ~slave_low;
  assign sda_in = ~sda_oe & ~force_sda;
  assign obs = {scl_oe, sda_oe, scl_sync, sda_sync, busy, bus_busy, stretch_timeout, arb_lost};

  i2c_line_conditioner #(
    .MIN_LOW(4), .MIN_HIGH(4), .SDA_HOLD(2), .FILT_LEN(2), .STRETCH_MAX(10), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .scl_req(scl_req), .sda_req(sda_req),
    .clear_flags(clear_flags), .scl_in(scl_in), .sda_in(sda_in),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_sync(scl_sync), .sda_sync(sda_sync),
    .busy(busy), .bus_busy(bus_busy), .stretch_timeout(stretch_timeout), .arb_lost(arb_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_bits(string name, int at, logic [7:0] mask, logic [7:0] val);
    exp_t e;
    int   i;
    e.name = name; e.at = at; e.mask = mask; e.val = val;
    i = sb.size();
    while (i > 0 && sb[i-1].at > at) i--;
    sb.insert(i, e);
  endfunction

  function automatic void expect1(string name, int at, int idx, logic v);
    logic [7:0] m;
    m = 8'(1) << idx;
    expect_bits(name, at, m, v ? m : 8'h00);
  endfunction

  // Scoreboard monitor.
  exp_t cur;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (cur.at != cyc || (obs & cur.mask) != cur.val) begin
        errors++;
        $display("FAIL %s cycle %0d (due %0d): got %b required %b mask %b",
                 cur.name, cyc, cur.at, obs & cur.mask, cur.val, cur.mask);
      end
    end
  end

  // SCL pulse-width monitor (first run after reset is partial and skipped).
  int   run;
  logic prev, armed = 1'b0, first;
  always @(negedge clk) begin
    if (!reset_n) begin
      armed = 1'b0;
    end else if (!armed) begin
      armed = 1'b1; first = 1'b1; prev = scl_oe; run = 1;
    end else if (scl_oe == prev) begin
      run++;
    end else begin
      if (!first) begin
        if (prev) begin
          checks++;
          if (run < 4) begin
            errors++;
            $display("FAIL scl_low_width cycle %0d: got %0d required >= 4", cyc, run);
          end
        end
`ifndef I2C_LINE_COND_STRETCH_EN
        else begin
          checks++;
          if (run < 5) begin
            errors++;
            $display("FAIL scl_high_width cycle %0d: got %0d required >= 5", cyc, run);
          end
        end
`endif
      end
      first = 1'b0; prev = scl_oe; run = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(int t);
    while (cyc < t) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, h, s, d, f;
    repeat (3) tick();
    expect_bits("reset_vals", cyc, 8'hFF, 8'b0011_0000);
    tick();
    reset_n = 1'b1;
    repeat (20) tick();

    // Toggle scl_req every cycle; width monitor enforces legal low/high times.
    expect1("busy_toggle", cyc, BBusy, 1'b1);
    for (int i = 0; i < 40; i++) begin
      scl_req = ~scl_req;
      tick();
    end
    repeat (20) tick();
    expect1("idle_after_toggle", cyc, BSclOe, 1'b0);
    tick();

    // Exact low/release trace; h = first cycle of S_HIGH.
    c = cyc;
    scl_req = 1'b0;
    expect1("busy_fall_req", c, BBusy, 1'b1);
    expect1("scl_oe_rise", c + 1, BSclOe, 1'b1);
    tick();
    scl_req = 1'b1;
    expect1("busy_rel_req", c + 1, BBusy, 1'b1);
    expect1("scl_oe_min_low", c + 4, BSclOe, 1'b1);
    expect1("scl_oe_fall", c + 5, BSclOe, 1'b0);
    expect1("scl_sync_lag", c + 8, BSclSync, 1'b0);
    expect1("scl_sync_rise", c + 9, BSclSync, 1'b1);
`ifdef I2C_LINE_COND_STRETCH_EN
    h = c + 10;
`else
    h = c + 6;
`endif
    wait_to(h);

    // START right after entering S_HIGH: waits for hold_cnt to reach MIN_HIGH-1.
    sda_req = 1'b0;
    expect1("sda_oe_wait_high", h + 3, BSdaOe, 1'b0);
    expect1("sda_oe_start", h + 4, BSdaOe, 1'b1);
    expect1("sda_sync_fall", h + 8, BSdaSync, 1'b0);
    expect1("bus_busy_pre", h + 8, BBusBusy, 1'b0);
    expect1("bus_busy_start", h + 9, BBusBusy, 1'b1);
    wait_to(h + 12);
    s = cyc;
    sda_req = 1'b1;
    expect1("sda_oe_stop", s + 1, BSdaOe, 1'b0);
    expect1("sda_sync_lag", s + 4, BSdaSync, 1'b0);
    expect1("sda_sync_rise", s + 5, BSdaSync, 1'b1);
    expect1("bus_busy_pre_stop", s + 5, BBusBusy, 1'b1);
    expect1("bus_busy_stop", s + 6, BBusBusy, 1'b0);
    wait_to(s + 20);

    // Both requests drop together: SCL first, SDA SDA_HOLD into S_LOW; glitch filtered.
    c = cyc;
    scl_req = 1'b0;
    sda_req = 1'b0;
    expect1("both_scl_first", c + 1, BSclOe, 1'b1);
    expect1("both_sda_hold", c + 1, BSdaOe, 1'b0);
    expect1("both_sda_wait", c + 3, BSdaOe, 1'b0);
    expect1("both_sda_rise", c + 4, BSdaOe, 1'b1);
    expect1("both_busy", c + 4, BBusy, 1'b1);
    wait_to(c + 4);
    scl_req = 1'b1;
    sda_req = 1'b1;
    expect1("glitch_sda_release", c + 5, BSdaOe, 1'b0);
    expect1("glitch_scl_release", c + 5, BSclOe, 1'b0);
    expect1("glitch_filtered_a", c + 6, BSdaSync, 1'b1);
    expect1("glitch_filtered_b", c + 8, BSdaSync, 1'b1);
    expect1("no_start_in_low", c + 9, BBusBusy, 1'b0);
    wait_to(c + 25);

    // Arbitration loss: clear first, then another master holds SDA low.
    d = cyc;
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    expect1("arb_cleared", d + 1, BArb, 1'b0);
    expect1("st_cleared", d + 1, BSt, 1'b0);
    wait_to(d + 4);
    f = cyc;
    force_sda = 1'b1;
    expect1("arb_not_on_start", f + 5, BArb, 1'b0);
    expect1("bus_busy_forced", f + 5, BBusBusy, 1'b1);
    expect1("arb_set", f + 6, BArb, 1'b1);
    wait_to(f + 8);
    clear_flags = 1'b1;
    expect1("arb_set_wins", f + 9, BArb, 1'b1);
    tick();
    clear_flags = 1'b0;
    wait_to(f + 10);
    force_sda = 1'b0;
    expect1("arb_sticky", f + 15, BArb, 1'b1);
    expect1("bus_busy_stop2", f + 15, BBusBusy, 1'b0);
    wait_to(f + 16);
    clear_flags = 1'b1;
    expect1("arb_clear", f + 17, BArb, 1'b0);
    tick();
    clear_flags = 1'b0;
    repeat (10) tick();

    // Reset mid-transfer releases both lines without a clock edge.
    c = cyc;
    scl_req = 1'b0;
    sda_req = 1'b0;
    expect_bits("pre_reset_driving", c + 5, 8'hC0, 8'hC0);
    wait_to(c + 6);
    reset_n = 1'b0;
    expect_bits("mid_reset_vals", c + 6, 8'hF7, 8'b0011_0000);
    tick();
    scl_req = 1'b1;
    sda_req = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (20) tick();
    expect_bits("post_reset_idle", cyc, 8'hFF, 8'b0011_0000);
    tick();

`ifdef I2C_LINE_COND_STRETCH_EN
    // Short stretch: stays in S_RELEASE, S_HIGH 2+FILT_LEN after pad rises, no timeout.
    c = cyc;
    scl_req = 1'b0;
    tick();
    scl_req = 1'b1;
    slave_low = 1'b1;
    expect1("str_release", c + 5, BSclOe, 1'b0);
    expect1("str_sync_low", c + 14, BSclSync, 1'b0);
    expect1("str_sync_high", c + 15, BSclSync, 1'b1);
    expect1("str_no_timeout", c + 15, BSt, 1'b0);
    expect1("str_high_hold", c + 19, BSclOe, 1'b0);
    expect1("str_high_exit", c + 20, BSclOe, 1'b1);
    wait_to(c + 11);
    slave_low = 1'b0;
    wait_to(c + 16);
    scl_req = 1'b0;
    wait_to(c + 20);
    scl_req = 1'b1;
    repeat (30) tick();

    // Long stretch: timeout once stretch_cnt reaches STRETCH_MAX, sticky until cleared.
    c = cyc;
    scl_req = 1'b0;
    tick();
    scl_req = 1'b1;
    slave_low = 1'b1;
    expect1("to_not_yet", c + 15, BSt, 1'b0);
    expect1("to_set", c + 16, BSt, 1'b1);
    expect1("to_sticky", c + 24, BSt, 1'b1);
    wait_to(c + 25);
    slave_low = 1'b0;
    wait_to(c + 32);
    clear_flags = 1'b1;
    expect1("to_before_clear", c + 32, BSt, 1'b1);
    expect1("to_cleared", c + 33, BSt, 1'b0);
    tick();
    clear_flags = 1'b0;
`else
    // Without stretch support S_RELEASE lasts one cycle even if a slave holds SCL low.
    c = cyc;
    scl_req = 1'b0;
    tick();
    scl_req = 1'b1;
    slave_low = 1'b1;
    expect1("nostr_release", c + 5, BSclOe, 1'b0);
    expect1("nostr_high_hold", c + 9, BSclOe, 1'b0);
    expect1("nostr_no_timeout", c + 9, BSt, 1'b0);
    expect1("nostr_high_exit", c + 10, BSclOe, 1'b1);
    wait_to(c + 6);
    scl_req = 1'b0;
    wait_to(c + 10);
    scl_req = 1'b1;
    slave_low = 1'b0;
`endif
    repeat (30) tick();

    for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
